// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the UART transmitter: request/data in, serial line and status out.
interface uart_tx_if;
   logic       trmt;
   logic [7:0] tx_data;
   logic       TX;
   logic       tx_done;
   logic       busy;

   modport master (output trmt, output tx_data, input TX, input tx_done, input busy);
   modport slave  (input trmt, input tx_data, output TX, output tx_done, output busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, [parity], stop bit; one BAUD_DIV-clk period per bit.
// Optional parity bit ahead of the stop bit when UART_TX_PARITY_EN is defined (sense set by PARITY_ODD).
module uart_tx #(
   parameter int unsigned BAUD_DIV   = 2604,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_tx_if.slave  bus
);

   localparam int unsigned CNT_W = 12;
   localparam int unsigned BIT_W = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned N = 11;
`else
   localparam int unsigned N = 10;
`endif

   // Reject configurations the 12-bit baud counter or the parity sense cannot represent.
   if (BAUD_DIV < 2 || BAUD_DIV > 4095 || PARITY_ODD > 1) begin : g_cfg_check
      $error("uart_tx: BAUD_DIV must be 2..4095 and PARITY_ODD 0 or 1");
   end

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_TRANSMIT = 1'b1
   } state_t;

   state_t           r_state,    w_state_nxt;
   logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
   logic [BIT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
   logic [N-1:0]     r_shift,    w_shift_nxt;
   logic             r_tx,       w_tx_nxt;
   logic             r_tx_done,  w_tx_done_nxt;
   logic             r_busy,     w_busy_nxt;

   logic [N-1:0]     w_frame;
   logic             w_baud_done;
   logic             w_last_bit;

`ifdef UART_TX_PARITY_EN
   assign w_frame = {1'b1, (^bus.tx_data) ^ 1'(PARITY_ODD), bus.tx_data, 1'b0};
`else
   assign w_frame = {1'b1, bus.tx_data, 1'b0};
`endif

   assign w_baud_done = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
   assign w_last_bit  = (r_bit_cnt == BIT_W'(N - 1));

   // Next-state and next-output logic; TX is re-registered from the shifter so trmt never reaches it combinationally.
   always_comb begin
      w_state_nxt    = r_state;
      w_baud_cnt_nxt = r_baud_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_tx_done_nxt  = r_tx_done;
      w_busy_nxt     = r_busy;
      w_tx_nxt       = (r_state == S_TRANSMIT) ? r_shift[0] : 1'b1;

      case (r_state)
         S_IDLE: begin
            if (bus.trmt) begin
               w_shift_nxt    = w_frame;
               w_baud_cnt_nxt = '0;
               w_bit_cnt_nxt  = '0;
               w_tx_done_nxt  = 1'b0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_TRANSMIT;
            end
         end
         S_TRANSMIT: begin
            if (w_baud_done) begin
               w_shift_nxt    = {1'b1, r_shift[N-1:1]};
               w_baud_cnt_nxt = '0;
               w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
               if (w_last_bit) begin
                  w_state_nxt   = S_IDLE;
                  w_tx_done_nxt = 1'b1;
                  w_busy_nxt    = 1'b0;
               end
            end else begin
               w_baud_cnt_nxt = r_baud_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // State and registered outputs; reset aborts any frame and forces the line idle-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '1;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_tx_done  <= w_tx_done_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign bus.TX      = r_tx;
   assign bus.tx_done = r_tx_done;
   assign bus.busy    = r_busy;

endmodule
